m68k_intc_rr: RTL

Parametrised successor to the team's fixed 7-input interrupt controller for the m68k Wishbone SoC. Supports N_SRC sources; each source has a programmable priority level, enable, edge/level mode, vector and autovector select. The block drives the CPU IPL lines and answers IACK cycles with a vector. When several sources share a level, it arbitrates them round-robin. It sits on the 8-bit Wishbone peripheral bus beside the timer and UART.

---
 rtl/intc_pkg.sv | 56 +++++
 rtl/intc_src_cell.sv | 40 ++++
 rtl/m68k_intc_rr.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared constants, types and the round-robin search used by m68k_intc_rr.
package intc_pkg;

  localparam int MAX_SRC    = 32;
  localparam int PEND_BASE  = 'h40;
  localparam int STATUS_ADR = 'h44;

  // CTRL[s] bit positions
  localparam int CTRL_LVL_LSB = 0;
  localparam int CTRL_EN_BIT  = 3;
  localparam int CTRL_EDGE_BIT = 4;
  localparam int CTRL_AV_BIT  = 5;

  localparam logic [7:0] AUTOVEC_BASE   = 8'd24;
  localparam logic [7:0] SPURIOUS_VEC   = 8'd24;
  localparam logic [7:0] VEC_RESET_BASE = 8'd64;

  // Field order matches the CTRL bit positions above.
  typedef struct packed {
    logic       autovec;
    logic       edge_mode;
    logic       enable;
    logic [2:0] level;
  } ctrl_t;

  typedef enum logic [1:0] {
    IACK_IDLE,
    IACK_RESOLVE,
    IACK_ACK,
    IACK_WAIT
  } iack_state_e;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // First set bit of cand strictly after ptr, wrapping at n.
  function automatic rr_pick_t rr_find_after(input logic [MAX_SRC-1:0] cand,
                                             input logic [4:0]         ptr,
                                             input int                 n);
    rr_pick_t pick;
    int       idx;
    pick = '0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && !pick.found && cand[idx[4:0]]) begin
        pick.found = 1'b1;
        pick.idx   = idx[4:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/intc_src_cell.sv
// One interrupt source: 2-flop synchroniser, rising-edge detect, pending flop.
module intc_src_cell (
  input  logic wb_clk_i,
  input  logic wb_reset_ni,
  input  logic irq,
  input  logic enable,
  input  logic edge_mode,
  input  logic clear,
  output logic pending
);

  logic sync_q1, sync_q2, prev_q;
  logic rise;

  // Synchronise the asynchronous request and keep one stage of history.
  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    if (!wb_reset_ni) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q1 <= irq;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign rise = sync_q2 & ~prev_q;

  // Pending: level follows the input, edge latches a rise; a rise wins over a clear.
  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni)   pending <= 1'b0;
    else if (!enable)   pending <= 1'b0;
    else if (edge_mode) pending <= rise | (pending & ~clear);
    else                pending <= sync_q2;
  end

endmodule

// File: rtl/m68k_intc_rr.sv
// m68k interrupt controller: N_SRC programmable sources, IPL encoding,
// IACK vector delivery with per-level round-robin arbitration.
module m68k_intc_rr
  import intc_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ADR_W = 7
) (
  input  logic             wb_clk_i,
  input  logic             wb_reset_ni,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic [7:0]       wb_dat_i,
  output logic [7:0]       wb_dat_o,
  output logic             wb_ack_o,
  input  logic [N_SRC-1:0] irq_i,
  input  logic             iack_i,
  input  logic [2:0]       iack_lvl_i,
  output logic             iack_ack_o,
  output logic [7:0]       iack_vec_o,
  output logic [2:0]       ipl_o
);

  ctrl_t              ctrl   [N_SRC];
  logic [7:0]         vec    [N_SRC];
  logic [7:0]         rd_src [N_SRC];
  logic [N_SRC-1:0]   pend, w1c, iack_clr;
  logic [MAX_SRC-1:0] pend_ext, cand;
  logic [4:0]         rr_ptr [8];
  logic [4:0]         last_src;
  logic               win_edge, win_edge_c;
  logic [7:0]         win_vec, rd_data;
  logic [2:0]         ipl_nxt;
  logic               bus_acc, bus_wr;
  rr_pick_t           pick;
  iack_state_e        state, state_nxt;

  // An access is taken on the edge that raises ack; a held strobe alternates.
  assign bus_acc = wb_stb_i & ~wb_ack_o;
  assign bus_wr  = bus_acc & wb_we_i;

  for (genvar s = 0; s < N_SRC; s++) begin : g_src
    ctrl_t      ctrl_q;
    logic [7:0] vec_q;
    logic       hit_ctrl, hit_vec;

    assign hit_ctrl = (wb_adr_i == ADR_W'(2 * s));
    assign hit_vec  = (wb_adr_i == ADR_W'(2 * s + 1));

    // Per-source configuration registers.
    always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
      // NOTE: the configuration file is flops, not RAM, and is reset because
      // every entry has a defined reset value.
      if (!wb_reset_ni) begin
        ctrl_q <= '0;
        vec_q  <= VEC_RESET_BASE + 8'(s);
      end else begin
        if (bus_wr && hit_ctrl) ctrl_q <= ctrl_t'(wb_dat_i[5:0]);
        if (bus_wr && hit_vec)  vec_q  <= wb_dat_i;
      end
    end

    assign ctrl[s]     = ctrl_q;
    assign vec[s]      = vec_q;
    assign rd_src[s]   = hit_ctrl ? {2'b00, ctrl_q} : (hit_vec ? vec_q : 8'h00);
    assign w1c[s]      = bus_wr && (wb_adr_i == ADR_W'(PEND_BASE + s / 8)) && wb_dat_i[s % 8];
    assign iack_clr[s] = (state == IACK_ACK) && win_edge && (last_src == 5'(s));

    intc_src_cell u_cell (
      .wb_clk_i    (wb_clk_i),
      .wb_reset_ni (wb_reset_ni),
      .irq         (irq_i[s]),
      .enable      (ctrl_q.enable),
      .edge_mode   (ctrl_q.edge_mode),
      .clear       (w1c[s] | iack_clr[s]),
      .pending     (pend[s])
    );
  end

  // Read mux, IPL maximum and IACK candidate vector.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    pend_ext = '0;
    cand     = '0;
    rd_data  = 8'h00;
    ipl_nxt  = 3'd0;
    for (int s = 0; s < N_SRC; s++) begin
      pend_ext[s] = pend[s];
      cand[s]     = pend[s] & ctrl[s].enable & (ctrl[s].level == iack_lvl_i);
      rd_data     = rd_data | rd_src[s];
      if (pend[s] && ctrl[s].enable && ctrl[s].level > ipl_nxt) ipl_nxt = ctrl[s].level;
    end
    for (int b = 0; b < 4; b++)
      if (wb_adr_i == ADR_W'(PEND_BASE + b)) rd_data = pend_ext[8*b +: 8];
    if (wb_adr_i == ADR_W'(STATUS_ADR)) rd_data = {last_src, ipl_o};
  end

  assign pick = rr_find_after(cand, rr_ptr[iack_lvl_i], N_SRC);

  // Vector and mode of the round-robin winner.
  always_comb begin
    win_vec    = SPURIOUS_VEC;
    win_edge_c = 1'b0;
    for (int s = 0; s < N_SRC; s++) begin
      if (pick.found && pick.idx == 5'(s)) begin
        win_vec    = ctrl[s].autovec ? AUTOVEC_BASE + 8'(iack_lvl_i) : vec[s];
        win_edge_c = ctrl[s].edge_mode;
      end
    end
  end

  // IACK FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) state <= IACK_IDLE;
    else              state <= state_nxt;
  end

  // IACK FSM next state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IACK_IDLE:    if (iack_i) state_nxt = IACK_RESOLVE;
      IACK_RESOLVE: state_nxt = IACK_ACK;
      IACK_ACK:     state_nxt = IACK_WAIT;
      IACK_WAIT:    if (!iack_i) state_nxt = IACK_IDLE;
      default:      state_nxt = IACK_IDLE;
    endcase
  end

  // Registered IACK outputs, winner bookkeeping and round-robin pointers.
  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      iack_ack_o <= 1'b0;
      iack_vec_o <= 8'h00;
      last_src   <= 5'd0;
      win_edge   <= 1'b0;
      for (int l = 0; l < 8; l++) rr_ptr[l] <= 5'(N_SRC - 1);
    end else begin
      iack_ack_o <= (state == IACK_RESOLVE);
      if (state == IACK_RESOLVE) begin
        iack_vec_o <= win_vec;
        win_edge   <= win_edge_c;
        if (pick.found) begin
          last_src           <= pick.idx;
          rr_ptr[iack_lvl_i] <= pick.idx;
        end
      end
    end
  end

  // Bus ack/data and the IPL output register.
  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
      ipl_o    <= 3'd0;
    end else begin
      wb_ack_o <= bus_acc;
      wb_dat_o <= bus_acc ? rd_data : 8'h00;
      ipl_o    <= ipl_nxt;
    end
  end

endmodule
